// File: rtl/fc_bp_layer_sc_if.sv
// Bundle of the stream inputs and frame-estimate outputs of the SC backprop layer.
// No latency of its own; it only groups the signals.
// No backpressure: the stream is paced by en, and results are announced by acc_valid.
interface fc_bp_layer_sc_if #(
   parameter int N_NEUR  = 8,
   parameter int N_DELTA = 5,
   parameter int CNT_W   = 10
);
   logic                        start;
   logic                        en;
   logic [N_NEUR*N_DELTA-1:0]   alpha;
   logic [N_NEUR*N_DELTA-1:0]   SIGN_alpha;
   logic [N_NEUR-1:0]           zp;
   logic [N_DELTA-1:0]          delta_in;
   logic [N_DELTA-1:0]          SIGN_delta_in;
   logic [N_NEUR-1:0]           delta_out;
   logic [N_NEUR-1:0]           SIGN_delta_out;
   logic [N_NEUR*CNT_W-1:0]     acc_out;
   logic                        acc_valid;
   logic                        busy;

   // The side that drives stimulus and consumes results.
   modport master (
      output start, en, alpha, SIGN_alpha, zp, delta_in, SIGN_delta_in,
      input  delta_out, SIGN_delta_out, acc_out, acc_valid, busy
   );

   // The layer itself.
   modport slave (
      input  start, en, alpha, SIGN_alpha, zp, delta_in, SIGN_delta_in,
      output delta_out, SIGN_delta_out, acc_out, acc_valid, busy
   );
endinterface

// File: rtl/fc_bp_layer_sc.sv
// SC backprop layer: per-neuron round-robin delta mux, zp gating, framed signed accumulation.
// delta_out is 1 cycle after its inputs; acc_out/acc_valid appear in the cycle after the last RUN cycle.
// No backpressure: en=0 stalls the frame (counters and accumulators frozen, stream outputs forced to 0).
module fc_bp_layer_sc #(
   parameter int N_NEUR    = 8,
   parameter int N_DELTA   = 5,
   parameter int SEL_W     = 3,
   parameter int FRAME_LEN = 256,
   parameter int FRM_W     = 8,
   parameter int CNT_W     = 10
) (
   input  logic                 CLK,
   input  logic                 INIT,
   fc_bp_layer_sc_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Symmetric saturation limits, so a frame estimate never flips sign on overflow.
   localparam logic signed [CNT_W-1:0] ACC_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic signed [CNT_W-1:0] ACC_MIN  = -ACC_MAX;
   localparam logic signed [CNT_W-1:0] ACC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0]        SEL_LAST = SEL_W'(N_DELTA - 1);
   localparam logic [FRM_W-1:0]        FRM_LAST = FRM_W'(FRAME_LEN - 1);
   localparam logic [SEL_W:0]          N_DELTA_W = (SEL_W+1)'(N_DELTA);

   state_t                          state_q, state_d;
   logic [SEL_W-1:0]                sel_q, sel_d;
   logic [FRM_W-1:0]                frm_q, frm_d;
   logic [N_NEUR-1:0][CNT_W-1:0]    acc_q, acc_d;
   logic [N_NEUR-1:0][CNT_W-1:0]    acc_inc;
   logic [N_NEUR-1:0]               dout_q, dout_d;
   logic [N_NEUR-1:0]               sout_q, sout_d;
   logic [N_NEUR*CNT_W-1:0]         acc_out_q, acc_out_d;
   logic                            acc_valid_q, acc_valid_d;
   logic [N_NEUR-1:0]               p_vec;
   logic [N_NEUR-1:0]               s_vec;

   // Per-neuron datapath: each neuron is offset by its index in the round-robin,
   // so at any cycle the neurons look at different deltas.
   for (genvar i = 0; i < N_NEUR; i++) begin : g_neur
      localparam logic [SEL_W:0] JOFF = (SEL_W+1)'(i % N_DELTA);

      logic [N_DELTA-1:0]       a_row;
      logic [N_DELTA-1:0]       sa_row;
      logic [SEL_W:0]           jsum;
      logic [SEL_W-1:0]         jsel;
      logic                     p;
      logic                     s;
      logic signed [CNT_W-1:0]  cur;
      logic signed [CNT_W-1:0]  nxt;

      assign a_row  = bus.alpha[i*N_DELTA +: N_DELTA];
      assign sa_row = bus.SIGN_alpha[i*N_DELTA +: N_DELTA];

      // Both operands are below N_DELTA, so one conditional subtract is a full mod.
      assign jsum = {1'b0, sel_q} + JOFF;
      assign jsel = (jsum >= N_DELTA_W) ? SEL_W'(jsum - N_DELTA_W) : SEL_W'(jsum);

      // Polar product: magnitude is the AND of the three streams, sign the XOR of the two signs,
      // and a zero-magnitude bit always carries a zero sign.
      assign p = bus.delta_in[jsel] & a_row[jsel] & bus.zp[i];
      assign s = p & (bus.SIGN_delta_in[jsel] ^ sa_row[jsel]);

      // Up/down step with saturation at the symmetric limits.
      assign cur = acc_q[i];
      assign nxt = !p ? cur :
                   s  ? ((cur == ACC_MIN) ? cur : cur - ACC_ONE) :
                        ((cur == ACC_MAX) ? cur : cur + ACC_ONE);

      assign p_vec[i]   = p;
      assign s_vec[i]   = s;
      assign acc_inc[i] = nxt;
   end

   // Frame FSM next-state and datapath updates; stream outputs default to 0 outside enabled RUN cycles.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      frm_d       = frm_q;
      acc_d       = acc_q;
      dout_d      = '0;
      sout_d      = '0;
      acc_out_d   = acc_out_q;
      acc_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               sel_d   = '0;
               frm_d   = '0;
               acc_d   = '0;
            end
         end
         RUN: begin
            if (bus.en) begin
               dout_d = p_vec;
               sout_d = s_vec;
               acc_d  = acc_inc;
               sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
               frm_d  = frm_q + FRM_W'(1);
               // Publish including this last cycle's contribution, so the
               // estimate and its valid pulse are both visible during DONE.
               if (frm_q == FRM_LAST) begin
                  state_d     = DONE;
                  acc_out_d   = acc_inc;
                  acc_valid_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any partial frame.
   always_ff @(posedge CLK) begin
      if (!INIT) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         frm_q       <= '0;
         acc_q       <= '0;
         dout_q      <= '0;
         sout_q      <= '0;
         acc_out_q   <= '0;
         acc_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         frm_q       <= frm_d;
         acc_q       <= acc_d;
         dout_q      <= dout_d;
         sout_q      <= sout_d;
         acc_out_q   <= acc_out_d;
         acc_valid_q <= acc_valid_d;
      end
   end

   assign bus.delta_out      = dout_q;
   assign bus.SIGN_delta_out = sout_q;
   assign bus.acc_out        = acc_out_q;
   assign bus.acc_valid      = acc_valid_q;
   assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fc_bp_layer_sc.sv
// Bench for fc_bp_layer_sc: two instances (CNT_W=10 and CNT_W=4) share one stimulus.
// A frame-level reference model is compared against both every cycle,
// and a few hand-computed literals pin the model.
module tb_fc_bp_layer_sc;
   localparam int NN  = 8;
   localparam int ND  = 5;
   localparam int FL  = 20;
   localparam int CA  = 10;
   localparam int CB  = 4;
   localparam int LIMA = (1 << (CA-1)) - 1;
   localparam int LIMB = (1 << (CB-1)) - 1;

   logic clk = 1'b0;
   logic init;
   always #5 clk = ~clk;

   fc_bp_layer_sc_if #(.N_NEUR(NN), .N_DELTA(ND), .CNT_W(CA)) ifa ();
   fc_bp_layer_sc_if #(.N_NEUR(NN), .N_DELTA(ND), .CNT_W(CB)) ifb ();

   assign ifb.start         = ifa.start;
   assign ifb.en            = ifa.en;
   assign ifb.alpha         = ifa.alpha;
   assign ifb.SIGN_alpha    = ifa.SIGN_alpha;
   assign ifb.zp            = ifa.zp;
   assign ifb.delta_in      = ifa.delta_in;
   assign ifb.SIGN_delta_in = ifa.SIGN_delta_in;

   fc_bp_layer_sc #(.N_NEUR(NN), .N_DELTA(ND), .SEL_W(3), .FRAME_LEN(FL), .FRM_W(5), .CNT_W(CA))
      u_dut_a (.CLK(clk), .INIT(init), .bus(ifa));
   fc_bp_layer_sc #(.N_NEUR(NN), .N_DELTA(ND), .SEL_W(3), .FRAME_LEN(FL), .FRM_W(5), .CNT_W(CB))
      u_dut_b (.CLK(clk), .INIT(init), .bus(ifb));

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   function automatic int sat(input int v, input int lim);
      if (v > lim) return lim;
      if (v < -lim) return -lim;
      return v;
   endfunction

   // ---------------- reference model (frame level) ----------------
   int              m_phase;   // 0 idle, 1 streaming, 2 result cycle
   int              m_k;       // enabled stream cycles so far in this frame
   int              accA [NN];
   int              accB [NN];
   logic [NN-1:0]   m_dout, m_sout;
   logic            m_valid;
   logic [NN*CA-1:0] m_accA;
   logic [NN*CB-1:0] m_accB;

   always @(posedge clk) begin
      if (!init) begin
         m_phase = 0; m_k = 0;
         m_dout = '0; m_sout = '0; m_valid = 1'b0;
         m_accA = '0; m_accB = '0;
         for (int i = 0; i < NN; i++) begin accA[i] = 0; accB[i] = 0; end
      end else begin
         m_dout = '0; m_sout = '0; m_valid = 1'b0;
         case (m_phase)
            0: if (ifa.start) begin
                  m_phase = 1; m_k = 0;
                  for (int i = 0; i < NN; i++) begin accA[i] = 0; accB[i] = 0; end
               end
            1: if (ifa.en) begin
                  for (int i = 0; i < NN; i++) begin
                     int  j;
                     bit  p, s;
                     j = (m_k + i) % ND;
                     p = ifa.delta_in[j] && ifa.alpha[i*ND+j] && ifa.zp[i];
                     s = p && (ifa.SIGN_delta_in[j] != ifa.SIGN_alpha[i*ND+j]);
                     m_dout[i] = p;
                     m_sout[i] = s;
                     if (p) begin
                        accA[i] = sat(accA[i] + (s ? -1 : 1), LIMA);
                        accB[i] = sat(accB[i] + (s ? -1 : 1), LIMB);
                     end
                  end
                  m_k++;
                  if (m_k == FL) begin
                     m_phase = 2;
                     m_valid = 1'b1;
                     for (int i = 0; i < NN; i++) begin
                        m_accA[i*CA +: CA] = CA'(accA[i]);
                        m_accB[i*CB +: CB] = CB'(accB[i]);
                     end
                  end
               end
            default: m_phase = 0;
         endcase
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("delta_out",      ifa.delta_out,      m_dout);
         check("SIGN_delta_out", ifa.SIGN_delta_out, m_sout);
         check("acc_valid",      ifa.acc_valid,      m_valid);
         check("busy",           ifa.busy,           m_phase != 0);
         check("acc_out_a",      ifa.acc_out,        m_accA);
         check("acc_out_b",      ifb.acc_out,        m_accB);
         check("delta_out_b",    ifb.delta_out,      m_dout);
         check("acc_valid_b",    ifb.acc_valid,      m_valid);
      end
   end

   // ---------------- directed stimulus ----------------
   logic [31:0] hist0, hist1;
   logic [NN-1:0] sgn_or;
   int lat;

   // Pulse start, then watch for acc_valid, counting edges after the sampling edge.
   // Optionally stall (en=0, start=1) for stall_len edges beginning after edge stall_at.
   task automatic run_frame(input int stall_at, input int stall_len);
      hist0 = '0; hist1 = '0; sgn_or = '0; lat = 100;
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (n <= 32) begin
            hist0[n-1] = ifa.delta_out[0];
            hist1[n-1] = ifa.delta_out[1];
         end
         sgn_or |= ifa.SIGN_delta_out;
         if (ifa.acc_valid) begin lat = n; break; end
         if (n >= stall_at && n < stall_at + stall_len) begin
            ifa.en = 1'b0; ifa.start = 1'b1;
         end else begin
            ifa.en = 1'b1; ifa.start = 1'b0;
         end
      end
      ifa.en = 1'b1; ifa.start = 1'b0;
      @(negedge clk);
   endtask

   logic [NN*CA-1:0] expA;
   logic [NN*CB-1:0] expB;
   logic [NN*ND-1:0] sa_bits;

   initial begin
      init = 1'b0;
      ifa.start = 1'b0; ifa.en = 1'b1;
      ifa.alpha = '1; ifa.SIGN_alpha = '0;
      ifa.zp = 8'hFF; ifa.delta_in = 5'b11111; ifa.SIGN_delta_in = '0;
      repeat (2) @(negedge clk);
      check("rst_busy",  ifa.busy, 1'b0);
      check("rst_valid", ifa.acc_valid, 1'b0);
      check("rst_acc",   ifa.acc_out, '0);
      check("rst_dout",  ifa.delta_out, '0);
      chk_en = 1'b1;
      init = 1'b1;
      @(negedge clk);

      // All-ones streams: every neuron fires every cycle.
      run_frame(1000, 0);
      check("t2_latency", lat, 20);
      check("t2_acc_a", ifa.acc_out, {8{10'd20}});
      check("t2_acc_b_sat", ifb.acc_out, {8{4'd7}});

      // Reset mid-frame discards everything, then a fresh frame runs full length.
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      repeat (6) @(negedge clk);
      init = 1'b0;
      repeat (2) @(negedge clk);
      check("t1_busy",  ifa.busy, 1'b0);
      check("t1_valid", ifa.acc_valid, 1'b0);
      check("t1_acc",   ifa.acc_out, '0);
      check("t1_dout",  {ifa.delta_out, ifa.SIGN_delta_out}, '0);
      init = 1'b1;
      @(negedge clk);
      run_frame(1000, 0);
      check("t1_latency", lat, 20);
      check("t1_acc_a", ifa.acc_out, {8{10'd20}});

      // Only delta 0 active: each neuron fires once per 5 cycles.
      ifa.delta_in = 5'b00001;
      run_frame(1000, 0);
      check("t3_n0_pattern", hist0, 32'h0000_8421);
      check("t3_n1_pattern", hist1, 32'h0008_4210);
      check("t3_acc_a", ifa.acc_out, {8{10'd4}});
      check("t3_acc_b", ifb.acc_out, {8{4'd4}});

      // Negative delta 0, with neuron 3's weight also negative.
      ifa.SIGN_delta_in = 5'b00001;
      sa_bits = '0; sa_bits[15] = 1'b1;
      ifa.SIGN_alpha = sa_bits;
      run_frame(1000, 0);
      for (int i = 0; i < NN; i++) begin
         expA[i*CA +: CA] = (i == 3) ? 10'd4 : 10'h3FC;
         expB[i*CB +: CB] = (i == 3) ? 4'd4  : 4'hC;
      end
      check("t4_acc_a", ifa.acc_out, expA);
      check("t4_acc_b", ifb.acc_out, expB);
      check("t4_sign_seen", sgn_or, 8'hF7);

      // Seven-cycle stall mid-frame with start held during the stall.
      ifa.delta_in = 5'b11111; ifa.SIGN_delta_in = '0; ifa.SIGN_alpha = '0;
      run_frame(8, 7);
      check("t5_latency", lat, 27);
      check("t5_acc_a", ifa.acc_out, {8{10'd20}});
      check("t5_idle_after", ifa.busy, 1'b0);

      // zp[2] held low: neuron 2 never fires.
      ifa.zp = 8'hFB;
      run_frame(1000, 0);
      for (int i = 0; i < NN; i++) begin
         expA[i*CA +: CA] = (i == 2) ? 10'd0 : 10'd20;
         expB[i*CB +: CB] = (i == 2) ? 4'd0  : 4'd7;
      end
      check("t6_acc_a", ifa.acc_out, expA);
      check("t6_acc_b", ifb.acc_out, expB);

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fc_bp_layer_sc.md
Name: fc_bp_layer_sc

Overview:
- Parametrised stochastic-computing backpropagation layer with N_NEUR neurons fed by N_DELTA downstream deltas.
- Per cycle, each neuron's polar delta bitstream is the product of zp[i] with one mux-selected delta_in[j]·alpha[i][j] term. The select is round-robin, which gives scaled addition by 1/N_DELTA.
- Adds frame control and per-neuron signed accumulators that return a binary delta estimate with a valid pulse, so the weight-update logic can use deltas without downstream counters.

Parameters:
- N_NEUR, 8, neurons in this layer (delta_out width).
- N_DELTA, 5, incoming deltas from the next layer.
- SEL_W, 3, select counter width; must satisfy 2^SEL_W >= N_DELTA.
- FRAME_LEN, 256, stream cycles per frame (enabled cycles only).
- FRM_W, 8, frame counter width; must satisfy 2^FRM_W >= FRAME_LEN.
- CNT_W, 10, signed accumulator width per neuron.

Ports:
- CLK  in  1  clock, rising edge.
- INIT  in  1  reset, synchronous, active-low.
- start  in  1  frame start request; sampled only in IDLE.
- en  in  1  stream enable; 0 stalls the frame.
- alpha  in  N_NEUR*N_DELTA  weight magnitude bits; bit i*N_DELTA+j = neuron i, delta j.
- SIGN_alpha  in  N_NEUR*N_DELTA  weight sign bits (1 = negative), same indexing.
- zp  in  N_NEUR  activation-derivative bitstreams.
- delta_in  in  N_DELTA  incoming delta magnitude bitstreams.
- SIGN_delta_in  in  N_DELTA  incoming delta signs.
- delta_out  out  N_NEUR  outgoing delta magnitude bitstreams (registered).
- SIGN_delta_out  out  N_NEUR  outgoing delta signs (registered).
- acc_out  out  N_NEUR*CNT_W  signed two's-complement frame estimates; neuron i at bits [i*CNT_W +: CNT_W].
- acc_valid  out  1  one-cycle pulse when acc_out updates.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Reset (INIT=0 at a clock edge) applies from any state, including mid-frame:
  - state=IDLE; sel_cnt, frm_cnt and all accumulators = 0.
  - delta_out, SIGN_delta_out, acc_out, acc_valid and busy all = 0.
  - A partially accumulated frame is discarded.
- FSM IDLE:
  - start=1 moves to RUN next cycle.
  - sel_cnt, frm_cnt and all accumulators clear on entry to RUN.
  - acc_out is held unchanged.
- FSM RUN, when en=1, each cycle:
  - Select for neuron i: j_i = (sel_cnt + i) mod N_DELTA.
  - Magnitude: p_i = delta_in[j_i] & alpha[i*N_DELTA+j_i] & zp[i].
  - Sign: s_i = p_i & (SIGN_delta_in[j_i] ^ SIGN_alpha[i*N_DELTA+j_i]).
  - delta_out[i] <= p_i and SIGN_delta_out[i] <= s_i; delta_out has 1-cycle latency from inputs.
  - Accumulator: acc_i += +1 if p_i & ~s_i, -1 if p_i & s_i, unchanged if p_i=0.
  - Accumulators saturate at +(2^(CNT_W-1)-1) and -(2^(CNT_W-1)-1); no wrap.
  - sel_cnt advances and wraps from N_DELTA-1 to 0.
  - frm_cnt increments; when frm_cnt = FRAME_LEN-1 the state moves to DONE.
- FSM RUN, when en=0:
  - delta_out and SIGN_delta_out <= 0.
  - sel_cnt, frm_cnt and accumulators are frozen; the frame is extended by the stall length.
- FSM DONE (exactly one cycle):
  - acc_out <= accumulators (including the final RUN cycle's contribution).
  - acc_valid=1; delta_out and SIGN_delta_out <= 0.
  - Next state IDLE.
- start is ignored in RUN and DONE; start in the cycle after DONE (IDLE) is accepted.
- Frame timing: start sampled at cycle t → RUN cycles t+1 … t+FRAME_LEN (with no stall) → acc_valid high during cycle t+FRAME_LEN+1.
- acc_out holds its value until the next DONE or reset.
- Simultaneous events: a reset edge overrides start and en.

Test Plan:
1. Reset mid-frame: start, run 6 enabled cycles, drive INIT=0 for 2 cycles → every output 0, busy=0, no acc_valid; a fresh start afterwards gives a full-length frame.
2. FRAME_LEN=20; alpha all 1; delta_in=5'b11111; all signs 0; zp=8'hFF; start at t → delta_out=8'hFF during t+2…t+21; acc_valid only at t+21; every acc_out=+20.
3. Same as 2 but delta_in=5'b00001 → each neuron fires 4 times per frame and acc_out=+4 each.
   - Neuron 0 fires on RUN cycles 0,5,10,15.
   - Neuron 1 fires on RUN cycles 4,9,14,19.
4. As 3 with SIGN_delta_in[0]=1 and SIGN_alpha bit 15 (neuron 3, j=0) =1 → neuron 3 acc=+4 and SIGN_delta_out[3]=0; all others acc=-4 with SIGN_delta_out=1 when firing.
5. As 2 with en=0 for 7 cycles mid-frame → delta_out=0 and counters frozen during the stall; acc_valid at t+28; acc_out=+20; a start asserted during RUN has no effect.
6. As 2 with CNT_W=4 → acc_out=+7 (saturated). A separate run of 2 with zp[2]=0 → neuron 2 acc_out=0.
